// File: rtl/proc_pkg.sv
// Shared processor-level types and constants used by the mask splitter.
package proc_pkg;

    localparam int WORD_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } split_state_t;

endpackage

// File: rtl/mask_splitter_lsb_isolate.sv
// Combinational lowest-set-bit isolator: one-hot of the lowest set bit, single-bit flag,
// and (with SPLIT_INDEX_EN) the binary position of that bit.
module lsb_isolate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]         data,
    output logic [WIDTH-1:0]         onehot,
    output logic                     is_single
`ifdef SPLIT_INDEX_EN
    ,
    output logic [$clog2(WIDTH)-1:0] index
`endif
);

    // Two's-complement trick: x & -x keeps only the lowest set bit; x & (x-1) clears it.
    assign onehot    = data & (~data + WIDTH'(1));
    assign is_single = (data & (data - WIDTH'(1))) == '0;

`ifdef SPLIT_INDEX_EN
    always_comb begin
        // NOTE: give every always_comb output a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        index = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (onehot[i]) index = ($clog2(WIDTH))'(i);
        end
    end
`endif

endmodule

// File: rtl/mask_splitter.sv
// Splits a WIDTH-bit mask into a stream of one-hot beats, lowest bit first.
// Optional feature: define SPLIT_INDEX_EN to add the registered out_index port.
module mask_splitter
    import proc_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_last
`ifdef SPLIT_INDEX_EN
    ,
    output logic [$clog2(WIDTH)-1:0] out_index
`endif
);

    split_state_t     state, state_nxt;
    logic [WIDTH-1:0] rem, rem_nxt;
    logic             accept, fire, load;
    logic [WIDTH-1:0] iso_onehot;
    logic             iso_single;
`ifdef SPLIT_INDEX_EN
    logic [$clog2(WIDTH)-1:0] iso_index;
`endif

    // Outputs are registered, so the isolator looks at the remainder the next cycle will hold.
    lsb_isolate #(.WIDTH(WIDTH)) u_iso (
        .data      (rem_nxt),
        .onehot    (iso_onehot),
        .is_single (iso_single)
`ifdef SPLIT_INDEX_EN
        ,
        .index     (iso_index)
`endif
    );

    // State register, together with the remainder and the registered beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rem      <= '0;
            out_data <= '0;
            out_last <= 1'b0;
`ifdef SPLIT_INDEX_EN
            out_index <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples
            // pre-edge values regardless of statement order.
            state <= state_nxt;
            rem   <= rem_nxt;
            if (state_nxt == IDLE) begin
                out_data <= '0;
                out_last <= 1'b0;
`ifdef SPLIT_INDEX_EN
                out_index <= '0;
`endif
            end else if (load) begin
                out_data <= iso_onehot;
                out_last <= iso_single;
`ifdef SPLIT_INDEX_EN
                out_index <= iso_index;
`endif
            end
        end
    end

    // Next-state logic; an accept overrides the retire of the previous mask's last beat.
    always_comb begin
        accept    = in_valid & in_ready;
        fire      = out_valid & out_ready;
        load      = accept | fire;
        rem_nxt   = rem;
        state_nxt = state;
        if (fire)   rem_nxt = rem & ~out_data;
        if (accept) rem_nxt = in_data;
        if (accept)
            state_nxt = BUSY;
        else if (fire && out_last)
            state_nxt = IDLE;
    end

    // Output logic.
    always_comb begin
        out_valid = (state == BUSY);
        in_ready  = (state == IDLE) | ((state == BUSY) & out_ready & out_last);
    end

endmodule
